// File: rtl/ft245_tx_packet_buffer.sv
// Store-and-forward Avalon-ST buffer feeding the FT245 sync FIFO bridge; releases whole packets,
// threshold-sized partial flushes, or (with FT245_TX_BUF_TIMEOUT_EN defined) idle-timeout flushes.
module ft245_tx_packet_buffer #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned EMPTY_WIDTH     = 1,
  parameter int unsigned DEPTH           = 64,
  parameter int unsigned FLUSH_THRESHOLD = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        sink_data,
  input  logic [EMPTY_WIDTH-1:0]       sink_empty,
  input  logic                         sink_startofpacket,
  input  logic                         sink_endofpacket,
  input  logic                         sink_valid,
  output logic                         sink_ready,
  output logic [DATA_WIDTH-1:0]        source_data,
  output logic [EMPTY_WIDTH-1:0]       source_empty,
  output logic                         source_startofpacket,
  output logic                         source_endofpacket,
  output logic                         source_valid,
  input  logic                         source_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = DATA_WIDTH + EMPTY_WIDTH + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_FLUSH} state_t;

  state_t             st, st_next;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level_q, pkt_count, flush_rem, flush_rem_next;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               wr_en, rd_en, wr_eop, rd_eop, timeout;

  assign sink_ready = (level_q != LW'(DEPTH));
  assign wr_en      = sink_valid && sink_ready;
  assign rd_en      = source_valid && source_ready;
  assign wr_eop     = wr_en && sink_endofpacket;
  assign rd_eop     = rd_en && source_endofpacket;
  assign level      = level_q;

  assign {source_data, source_empty, source_startofpacket, source_endofpacket} = mem[rd_ptr];

  assign source_valid = ((st == ST_SEND)  && (level_q   != '0)) ||
                        ((st == ST_FLUSH) && (flush_rem != '0));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {sink_data, sink_empty, sink_startofpacket, sink_endofpacket};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      pkt_count <= '0;
      st        <= ST_IDLE;
      flush_rem <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      level_q <= level_q + LW'(1);
      else if (!wr_en && rd_en) level_q <= level_q - LW'(1);
      if (wr_eop && !rd_eop)      pkt_count <= pkt_count + LW'(1);
      else if (!wr_eop && rd_eop) pkt_count <= pkt_count - LW'(1);
      st        <= st_next;
      flush_rem <= flush_rem_next;
    end
  end

`ifdef FT245_TX_BUF_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_timer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_timer <= '0;
    end else if (wr_en || (level_q == '0)) begin
      idle_timer <= '0;
    end else if ((st == ST_IDLE) && (idle_timer != TW'(TIMEOUT_CYCLES-1))) begin
      idle_timer <= idle_timer + TW'(1);
    end
  end

  assign timeout = (idle_timer == TW'(TIMEOUT_CYCLES-1)) && (level_q != '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // A flush covers only the beats present when it starts; later writes wait for the next release.
  always_comb begin
    st_next        = st;
    flush_rem_next = flush_rem;
    case (st)
      ST_IDLE: begin
        if (pkt_count != '0) begin
          st_next = ST_SEND;
        end else if ((level_q >= LW'(FLUSH_THRESHOLD)) || timeout) begin
          st_next        = ST_FLUSH;
          flush_rem_next = level_q;
        end
      end
      ST_SEND: begin
        if (rd_eop) st_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (rd_en) begin
          flush_rem_next = flush_rem - LW'(1);
          if (flush_rem == LW'(1)) st_next = ST_IDLE;
        end
      end
      default: st_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft245_tx_packet_buffer.sv
// Self-checking bench for ft245_tx_packet_buffer: queue-based reference model plus directed tests.
module tb_ft245_tx_packet_buffer;
  localparam int DEPTH = 64;
  localparam int THR   = 16;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] sink_data = '0;
  logic [0:0] sink_empty = '0;
  logic       sink_startofpacket = 1'b0, sink_endofpacket = 1'b0, sink_valid = 1'b0;
  logic       sink_ready;
  logic [7:0] source_data;
  logic [0:0] source_empty;
  logic       source_startofpacket, source_endofpacket, source_valid;
  logic       source_ready = 1'b0;
  logic [6:0] level;

  ft245_tx_packet_buffer #(
    .DATA_WIDTH(8), .EMPTY_WIDTH(1), .DEPTH(DEPTH), .FLUSH_THRESHOLD(THR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_empty(sink_empty),
    .sink_startofpacket(sink_startofpacket), .sink_endofpacket(sink_endofpacket),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .source_data(source_data), .source_empty(source_empty),
    .source_startofpacket(source_startofpacket), .source_endofpacket(source_endofpacket),
    .source_valid(source_valid), .source_ready(source_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic e; logic s; logic p;} beat_t;

  beat_t mq[$];   // model contents
  beat_t rx[$];   // beats actually read from the DUT
  int    mmode = 0;  // 0 holding, 1 releasing a packet, 2 flushing
  int    mflush = 0;
  int    mtimer = 0;
  int    total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eops_stored();
    int n = 0;
    foreach (mq[i]) if (mq[i].p) n++;
    return n;
  endfunction

  always @(negedge clk) begin : model
    bit    ev, wr, rd, tmo;
    int    sz;
    beat_t f;
    if (!reset_n) begin
      mq.delete();
      mmode = 0; mflush = 0; mtimer = 0;
    end else begin
      sz = mq.size();
      ev = (mmode == 1) ? (sz != 0) : (mmode == 2) ? (mflush != 0) : 1'b0;
      chk("m_source_valid", int'(source_valid), int'(ev));
      chk("m_sink_ready", int'(sink_ready), int'(sz != DEPTH));
      chk("m_level", int'(level), sz);
      if (ev && sz > 0) begin
        f = mq[0];
        chk("m_data", int'(source_data), int'(f.d));
        chk("m_empty", int'(source_empty), int'(f.e));
        chk("m_sop", int'(source_startofpacket), int'(f.s));
        chk("m_eop", int'(source_endofpacket), int'(f.p));
      end
      wr = sink_valid && (sz != DEPTH);
      rd = ev && source_ready;
      if (rd) rx.push_back('{d:source_data, e:source_empty[0], s:source_startofpacket, p:source_endofpacket});
`ifdef FT245_TX_BUF_TIMEOUT_EN
      tmo = (mtimer == TO-1) && (sz != 0);
      if (wr || sz == 0) mtimer = 0;
      else if (mmode == 0 && mtimer < TO-1) mtimer++;
`else
      tmo = 1'b0;
`endif
      case (mmode)
        0: if (eops_stored() != 0) mmode = 1;
           else if (sz >= THR || tmo) begin mmode = 2; mflush = sz; end
        1: if (rd && mq[0].p) mmode = 0;
        default: if (rd) begin mflush--; if (mflush == 0) mmode = 0; end
      endcase
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back('{d:sink_data, e:sink_empty[0], s:sink_startofpacket, p:sink_endofpacket});
    end
  end

  task automatic put(input logic [7:0] d, input logic s, input logic p, input logic e);
    bit acc = 1'b0;
    sink_data = d; sink_startofpacket = s; sink_endofpacket = p; sink_empty = e; sink_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = sink_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("put_timeout", 0, 1);
    sink_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rx.delete();
  endtask

  task automatic check_rx(input string nm, input int base, input int n);
    chk({nm, "_count"}, rx.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rx.size()) chk({nm, "_data"}, int'(rx[i].d), (base + i) & 255);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int first;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", int'(source_valid), 0);
    chk("rst_sink_ready", int'(sink_ready), 1);
    chk("rst_level", int'(level), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // T1: one packet of 5 beats
    source_ready = 1'b1;
    put(8'h11, 1, 0, 0); put(8'h12, 0, 0, 0); put(8'h13, 0, 0, 0); put(8'h14, 0, 0, 0);
    put(8'h15, 0, 1, 1);
    @(negedge clk);
    chk("t1_valid_n1", int'(source_valid), 0);
    @(negedge clk);
    chk("t1_valid_n2", int'(source_valid), 1);
    chk("t1_first_data", int'(source_data), 8'h11);
    idle(10);
    check_rx("t1", 8'h11, 5);
    if (rx.size() == 5) begin
      chk("t1_sop", int'(rx[0].s), 1);
      chk("t1_eop", int'(rx[4].p), 1);
      chk("t1_empty", int'(rx[4].e), 1);
      chk("t1_mid_eop", int'(rx[2].p), 0);
    end
    chk("t1_level", int'(level), 0);

    // T2: threshold flush of 16, 17th beat stays behind
    do_reset();
    source_ready = 1'b1;
    for (int i = 0; i < 16; i++) put(8'(8'h20 + i), 0, 0, 0);
    put(8'h30, 0, 0, 0);
    idle(40);
`ifdef FT245_TX_BUF_TIMEOUT_EN
    check_rx("t2", 8'h20, 17);
    chk("t2_level", int'(level), 0);
`else
    check_rx("t2", 8'h20, 16);
    chk("t2_level", int'(level), 1);
`endif

    // T3: fill to full with output stalled, then drain
    do_reset();
    source_ready = 1'b0;
    for (int i = 0; i < 64; i++) put(8'(8'h40 + i), 0, 0, 0);
    chk("t3_full_ready", int'(sink_ready), 0);
    chk("t3_full_level", int'(level), 64);
    sink_data = 8'hEE; sink_valid = 1'b1;
    idle(3);
    chk("t3_hold_level", int'(level), 64);
    source_ready = 1'b1;
    idle(1);
    source_ready = 1'b0; sink_valid = 1'b0;
    chk("t3_read_no_write", int'(level), 63);
    chk("t3_one_read", rx.size(), 1);
    source_ready = 1'b1;
    idle(150);
    check_rx("t3", 8'h40, 64);
    chk("t3_level", int'(level), 0);

    // T4: partial data then idle
    do_reset();
    source_ready = 1'b1;
    put(8'h81, 0, 0, 0); put(8'h82, 0, 0, 0); put(8'h83, 0, 0, 0);
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (source_valid && first < 0) first = k;
      @(posedge clk);
    end
    idle(5);
`ifdef FT245_TX_BUF_TIMEOUT_EN
    chk("t4_delay_in_8_9", int'(first >= 8 && first <= 9), 1);
    check_rx("t4", 8'h81, 3);
    chk("t4_level", int'(level), 0);
`else
    chk("t4_no_output", first, -1);
    chk("t4_level", int'(level), 3);
    chk("t4_rx", rx.size(), 0);
`endif

    // T5: continuous single-beat packets
    do_reset();
    source_ready = 1'b1;
    for (int i = 0; i < 40; i++) put(8'(8'hA0 + i), 1, 1, 1'(i));
    idle(100);
    check_rx("t5", 8'hA0, 40);
    for (int i = 0; i < 40; i++)
      if (i < rx.size()) chk("t5_empty", int'(rx[i].e), i & 1);
    chk("t5_level", int'(level), 0);

    // T6: reset in the middle of a release
    do_reset();
    source_ready = 1'b0;
    put(8'h90, 1, 0, 0);
    for (int i = 1; i < 6; i++) put(8'(8'h90 + i), 0, 0, 0);
    put(8'h96, 0, 1, 0);
    idle(3);
    chk("t6_send_valid", int'(source_valid), 1);
    chk("t6_send_level", int'(level), 7);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(source_valid), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_ready", int'(sink_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rx.delete();
    source_ready = 1'b1;
    put(8'hB1, 1, 0, 0); put(8'hB2, 0, 0, 0); put(8'hB3, 0, 1, 0);
    idle(10);
    check_rx("t6", 8'hB1, 3);
    chk("t6_level", int'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
